f1_reaction_timer: RTL

- Driver-side counterpart to the F1 start-light sequencer: watches the 8-bit light pattern and the driver's push-button, and measures reaction time from lights-out to press.
- Counts in ticks from the shared clktick divider (N set for 1 ms/tick at top level).
- Flags jump starts and timeouts.
- Result feeds the 7-seg/hex display path.

---
 rtl/f1_pkg.sv | 16 +
 rtl/rising_edge_det.sv | 18 +
 rtl/f1_reaction_timer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared types for the F1 start-light sequencer and the driver reaction timer.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ALL_ON,
    TIMING,
    DONE,
    FALSE_START
  } rt_state_t;

  localparam logic [7:0] LIGHTS_OFF = 8'h00;
  localparam logic [7:0] LIGHTS_ALL = 8'hFF;

endpackage

// File: rtl/rising_edge_det.sv
// Rising-edge detector: registered previous value, combinational one-cycle pulse.
module rising_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/f1_reaction_timer.sv
// Driver reaction timer: measures ticks from lights-out to button press,
// flagging jump starts and timeouts.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_TICKS = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic [WIDTH-1:0] react_time,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_TICKS);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (&v) return v;
    return v + WIDTH'(1);
  endfunction

  rt_state_t        state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_inc;
  logic             press;

  // The edge detector runs every cycle, so presses seen while disabled are consumed.
  rising_edge_det u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (btn),
    .pulse (press)
  );

  assign count_inc = sat_inc(count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      react_time <= '0;
      valid      <= 1'b0;
      jump_start <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (lights != LIGHTS_OFF) begin
              state      <= ARMED;
              jump_start <= 1'b0;
              timeout    <= 1'b0;
            end
          end

          ARMED: begin
            if (press)                    state <= FALSE_START;
            else if (lights == LIGHTS_ALL) state <= ALL_ON;
            else if (lights == LIGHTS_OFF) state <= IDLE;
          end

          // A press coinciding with lights-out is still a jump start.
          ALL_ON: begin
            if (press) begin
              state <= FALSE_START;
            end else if (lights == LIGHTS_OFF) begin
              state <= TIMING;
              count <= '0;
            end
          end

          // A tick in the press cycle is not added to the result.
          TIMING: begin
            if (press) begin
              react_time <= count;
              valid      <= 1'b1;
              state      <= DONE;
            end else if (tick && (count_inc == MAX_W)) begin
              count      <= count_inc;
              react_time <= MAX_W;
              timeout    <= 1'b1;
              valid      <= 1'b1;
              state      <= DONE;
            end else if (lights != LIGHTS_OFF) begin
              state <= ARMED;
              count <= '0;
            end else if (tick) begin
              count <= count_inc;
            end
          end

          DONE: begin
            if (lights != LIGHTS_OFF) begin
              state      <= ARMED;
              timeout    <= 1'b0;
              jump_start <= 1'b0;
            end
          end

          // jump_start remains visible until the next sequence arms.
          FALSE_START: begin
            jump_start <= 1'b1;
            if (lights == LIGHTS_OFF) state <= IDLE;
          end

          default: state <= IDLE;
        endcase

        if ((state == ARMED || state == ALL_ON) && press) jump_start <= 1'b1;
      end
    end
  end

endmodule
